code_gen: RTL and testbench
===========================

// Module: code_gen
// PURPOSE
//  Stimulus encoder for the Slt/En pulse counter. It takes a target pair (Count0, Count1) and
//  emits the matching Slt/En stream: Count0 slot-0 symbols, then Count1 slot-1 symbols.
//  The counter downstream then ends with Output0==Count0 and Output1==Count1.
//  It sits between the test controller (Start/Ready handshake) and the counter's Slt/En inputs.
// PARAMETERS
//  CNT_WIDTH  8  width of Count0/Count1/Sent0/Sent1
//  SLT1_LEN   4  enabled cycles per slot-1 symbol (Slt=1); must be >=1
//  GAP        0  idle cycles (En=0, Slt held) after every symbol; 0..15
// PORTS
//  Clk     in   1          single clock; all state updates on posedge
//  Reset   in   1          synchronous, active-high reset
//  Start   in   1          request valid; accepted when Start&&Ready at a posedge
//  Count0  in   CNT_WIDTH  number of slot-0 symbols; sampled at acceptance
//  Count1  in   CNT_WIDTH  number of slot-1 symbols; sampled at acceptance
//  Ready   out  1          1 iff FSM in IDLE
//  Slt     out  1          registered slot select to counter
//  En      out  1          registered enable to counter
//  Busy    out  1          1 iff FSM in SEND0/SEND1/GAPW
//  Done    out  1          one-cycle pulse when a job completes
//  Sent0   out  CNT_WIDTH  slot-0 symbols completed in the current/last job
//  Sent1   out  CNT_WIDTH  slot-1 symbols completed in the current/last job
// BEHAVIOUR
//  Reset (sync): state=IDLE; Slt=0, En=0, Done=0, Sent0=0, Sent1=0, Busy=0.
//   Ready=1 from the first cycle after Reset deasserts.
//  Reset mid-job aborts it; no Done is issued, and the latched counts are discarded.
//  States: IDLE, SEND0, SEND1, GAPW, FIN. A per-symbol cycle counter runs alongside.
//  IDLE: on Start&&Ready at edge k, latch the counts and clear Sent0/Sent1. The next state is:
//   SEND0 if Count0!=0;
//   else SEND1 if Count1!=0;
//   else FIN.
//  SEND0: En=1, Slt=0 for exactly 1 cycle per symbol. The first En=1 is in cycle k+1.
//  SEND1: En=1, Slt=1 for SLT1_LEN consecutive cycles per symbol.
//  Sent0/Sent1 increment at the edge ending the last enabled cycle of a symbol.
//  After each symbol: if GAP>0, go to GAPW for GAP cycles (En=0, Slt unchanged).
//   Then go to the next symbol, or to SEND1/FIN when the group is exhausted.
//  The SEND0->SEND1 transition with GAP=0 is back-to-back: Slt changes 0->1 with En staying 1.
//  FIN: Done=1 and En=0 for exactly one cycle, then IDLE.
//  Slt keeps its last value in IDLE/FIN and returns to 0 only on Reset.
//  Job length: Count0*(1+GAP) + Count1*(SLT1_LEN+GAP) cycles, plus 1 cycle for FIN.
//  Start while Busy or in FIN is ignored; the held Count inputs have no effect.
//  Start on the same edge as Reset is ignored (Reset wins).
//  Max counts (all-ones) must not wrap: Sent saturates exactly at Count.
// TESTING
//  1 Reset held 3 cycles, then release -> Slt=En=Done=0, Sent0=Sent1=0, Ready=1 next cycle.
//  2 GAP=0, Count0=3, Count1=2, Start at edge k ->
//     En=1,Slt=0 cycles k+1..k+3; En=1,Slt=1 cycles k+4..k+11;
//     Done at k+12; Sent0=3, Sent1=2.
//  3 GAP=1, Count0=2, Count1=1 ->
//     En pattern 1,0,1,0,1,1,1,1,0 with Slt 0,0,0,0,1,1,1,1,1;
//     Done at the 10th cycle after acceptance.
//  4 Count0=0, Count1=0 -> no En pulse; Done in cycle k+1; Ready=1 in cycle k+2.
//  5 Start pulsed during SEND1 with Count0=9 -> ignored; the job finishes with original counts,
//     Sent0 unchanged.
//  6 Reset asserted at cycle k+5 of job (4,4) -> En=0 at k+6, no Done, Sent=0, Ready=1 after release.
//     Feed the stream into the counter and check Output0/Output1 equal Count0/Count1 for jobs
//     (1,0), (0,1), (5,7).

Source files
------------

// File: rtl/code_gen.sv
// code_gen: emits the Slt/En symbol stream that makes the slot pulse counter reach (Count0, Count1)
module code_gen #(
    parameter int CNT_WIDTH = 8,
    parameter int SLT1_LEN  = 4,
    parameter int GAP       = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [CNT_WIDTH-1:0] Count0,
    input  logic [CNT_WIDTH-1:0] Count1,
    output logic                 Ready,
    output logic                 Slt,
    output logic                 En,
    output logic                 Busy,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] Sent0,
    output logic [CNT_WIDTH-1:0] Sent1
);
    localparam int CYC_MAX = SLT1_LEN > GAP ? SLT1_LEN : GAP;
    localparam int CW = $clog2(CYC_MAX + 1);
    typedef enum logic [2:0] {IDLE, SEND0, SEND1, GAPW, FIN} state_t;
    state_t state;
    logic [CNT_WIDTH-1:0] c0, c1, s0n, s1n, n0, n1;
    logic [CW-1:0] cyc;
    logic sym1_end, adv, go0, go1;
    assign Ready = state == IDLE;
    assign Busy = state inside {SEND0, SEND1, GAPW};
    assign s0n = Sent0 + 1'b1;
    assign s1n = Sent1 + 1'b1;
    assign n0 = state == SEND0 ? s0n : Sent0;
    assign n1 = state == SEND1 ? s1n : Sent1;
    assign sym1_end = state == SEND1 && cyc == CW'(SLT1_LEN - 1);
    assign adv = state == SEND0 || sym1_end || (state == GAPW && cyc == CW'(GAP - 1));
    // Slt tracks which group is in flight, including through the gap that follows a symbol
    assign go0 = !Slt && n0 != c0;
    assign go1 = !go0 && n1 != c1;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Slt   <= 1'b0;
            En    <= 1'b0;
            Done  <= 1'b0;
            Sent0 <= '0;
            Sent1 <= '0;
            c0    <= '0;
            c1    <= '0;
            cyc   <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    c0    <= Count0;
                    c1    <= Count1;
                    Sent0 <= '0;
                    Sent1 <= '0;
                    cyc   <= '0;
                    if (Count0 != '0) begin
                        state <= SEND0;
                        En    <= 1'b1;
                        Slt   <= 1'b0;
                    end else if (Count1 != '0) begin
                        state <= SEND1;
                        En    <= 1'b1;
                        Slt   <= 1'b1;
                    end else begin
                        state <= FIN;
                        Done  <= 1'b1;
                    end
                end
                SEND0, SEND1, GAPW: begin
                    cyc <= cyc + 1'b1;
                    if (state == SEND0) Sent0 <= s0n;
                    if (sym1_end) Sent1 <= s1n;
                    if (adv) begin
                        cyc <= '0;
                        if (state != GAPW && GAP > 0) begin
                            state <= GAPW;
                            En    <= 1'b0;
                        end else if (go0) begin
                            state <= SEND0;
                            En    <= 1'b1;
                            Slt   <= 1'b0;
                        end else if (go1) begin
                            state <= SEND1;
                            En    <= 1'b1;
                            Slt   <= 1'b1;
                        end else begin
                            state <= FIN;
                            En    <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_code_gen.sv
// tb_code_gen: randomized and directed checks of code_gen against a stream-level model
module tb_code_gen;
    localparam int W = 8;
    localparam int L1 = 4;
    localparam int OW = 5 + 2 * W;
    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
    logic [W-1:0] count0 = '0, count1 = '0;
    logic ready_a, slt_a, en_a, busy_a, done_a, ready_b, slt_b, en_b, busy_b, done_b;
    logic [W-1:0] sent0_a, sent1_a, sent0_b, sent1_b;
    logic [OW-1:0] obs_a, obs_b;
    logic [1:0] last_slt = 2'b00;
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    code_gen #(.CNT_WIDTH(W), .SLT1_LEN(L1), .GAP(0)) dut_a (
        .Clk(clk), .Reset(rst), .Start(start_a), .Count0(count0), .Count1(count1),
        .Ready(ready_a), .Slt(slt_a), .En(en_a), .Busy(busy_a), .Done(done_a),
        .Sent0(sent0_a), .Sent1(sent1_a));
    code_gen #(.CNT_WIDTH(W), .SLT1_LEN(L1), .GAP(1)) dut_b (
        .Clk(clk), .Reset(rst), .Start(start_b), .Count0(count0), .Count1(count1),
        .Ready(ready_b), .Slt(slt_b), .En(en_b), .Busy(busy_b), .Done(done_b),
        .Sent0(sent0_b), .Sent1(sent1_b));
    assign obs_a = {en_a, slt_a, done_a, busy_a, ready_a, sent0_a, sent1_a};
    assign obs_b = {en_b, slt_b, done_b, busy_b, ready_b, sent0_b, sent1_b};

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_slt = 2'b00;
        @(negedge clk);
        n_vec += 2;
        if (obs_a !== {5'b00001, {2*W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_a got %h exp %h", obs_a, {5'b00001, {2*W{1'b0}}});
        end
        if (obs_b !== {5'b00001, {2*W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_b got %h exp %h", obs_b, {5'b00001, {2*W{1'b0}}});
        end
    endtask

    // poke >= 0 pulses Start with junk counts during that job cycle; it must be ignored
    task automatic run_job(input int g, input int c0, input int c1, input int poke);
        logic [OW-1:0] exp_q[$];
        logic [OW-1:0] obs;
        logic [W-1:0] s0 = '0, s1 = '0;
        logic sl = last_slt[g];
        int o0 = 0, o1 = 0;
        for (int i = 0; i < c0; i++) begin
            exp_q.push_back({5'b10010, s0, s1});
            s0++;
            sl = 1'b0;
            for (int j = 0; j < g; j++) exp_q.push_back({5'b00010, s0, s1});
        end
        for (int i = 0; i < c1; i++) begin
            sl = 1'b1;
            for (int j = 0; j < L1; j++) exp_q.push_back({5'b11010, s0, s1});
            s1++;
            for (int j = 0; j < g; j++) exp_q.push_back({5'b01010, s0, s1});
        end
        exp_q.push_back({1'b0, sl, 3'b100, s0, s1});
        last_slt[g] = sl;
        @(negedge clk);
        count0 = W'(c0);
        count1 = W'(c1);
        if (g != 0) start_b = 1'b1; else start_a = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            obs = g != 0 ? obs_b : obs_a;
            n_vec++;
            if (obs !== exp_q[i]) begin
                n_err++;
                $display("FAIL job g%0d (%0d,%0d) cyc %0d got %h exp %h", g, c0, c1, i + 1, obs, exp_q[i]);
            end
            o0 += int'(obs[OW-1] & ~obs[OW-2]);
            o1 += int'(obs[OW-1] & obs[OW-2]);
            if (i == poke) begin
                count0 = 8'd9;
                count1 = 8'd9;
                if (g != 0) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        obs = g != 0 ? obs_b : obs_a;
        n_vec += 2;
        if (obs !== {1'b0, sl, 3'b001, s0, s1}) begin
            n_err++;
            $display("FAIL idle_after g%0d (%0d,%0d) got %h exp %h", g, c0, c1, obs, {1'b0, sl, 3'b001, s0, s1});
        end
        if (o0 != c0 || o1 != c1 * L1) begin
            n_err++;
            $display("FAIL counter g%0d got %0d,%0d exp %0d,%0d", g, o0, o1 / L1, c0, c1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        count0 = 8'd4;
        count1 = 8'd4;
        start_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            n_vec++;
            if (en_a !== 1'b1) begin
                n_err++;
                $display("FAIL mid_en cyc %0d got %b exp 1", i, en_a);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({en_a, done_a, busy_a, sent0_a, sent1_a} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got %h exp 0", {en_a, done_a, busy_a, sent0_a, sent1_a});
        end
        rst = 1'b0;
        last_slt = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ready_a, done_a, en_a, slt_a} !== 4'b1000) begin
                n_err++;
                $display("FAIL mid_after cyc %0d got %b exp 1000", i, {ready_a, done_a, en_a, slt_a});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(0, 30)));
        end
    endtask

    initial begin
        test_reset();
        run_job(0, 3, 2, -1);
        run_job(1, 2, 1, -1);
        run_job(0, 0, 0, -1);
        run_job(1, 0, 0, -1);
        run_job(0, 2, 3, 6);
        run_job(1, 3, 2, 4);
        test_reset_mid();
        for (int g = 0; g < 2; g++) begin
            run_job(g, 1, 0, -1);
            run_job(g, 0, 1, -1);
            run_job(g, 5, 7, -1);
        end
        test_random();
        run_job(0, 255, 255, 300);
        run_job(1, 255, 1, -1);
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
